// File: rtl/vref_cal_pkg.sv
// rtl/vref_cal_pkg.sv - shared types and widths for the receiver Vref calibration sweep
package vref_cal_pkg;

    localparam int VREF_W = 4;
    localparam int LANES  = 16;
    localparam int LEN_W  = VREF_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_TEST,
        S_EVAL,
        S_FINAL,
        S_DONE
    } vref_state_t;

endpackage

// File: rtl/vref_run_tracker.sv
// rtl/vref_run_tracker.sv - tracks current and longest contiguous run of passing Vref codes
module vref_run_tracker
    import vref_cal_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              update,
    input  logic              pass,
    input  logic [VREF_W-1:0] code,
    output logic [VREF_W-1:0] best_start,
    output logic [LEN_W-1:0]  best_len
);

    logic [VREF_W-1:0] cur_start;
    logic [LEN_W-1:0]  cur_len;
    logic [VREF_W-1:0] run_start;
    logic [LEN_W-1:0]  run_len;

    // Candidate run if this code passes: a new run starts here when none is open
    always_comb begin
        run_start = (cur_len == '0) ? code : cur_start;
        run_len   = cur_len + LEN_W'(1);
    end

    // Strictly-greater replacement keeps the lower-code run on a tie
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_start  <= '0;
            cur_len    <= '0;
            best_start <= '0;
            best_len   <= '0;
        end else if (clear) begin
            cur_start  <= '0;
            cur_len    <= '0;
            best_start <= '0;
            best_len   <= '0;
        end else if (update) begin
            if (pass) begin
                cur_start <= run_start;
                cur_len   <= run_len;
                if (run_len > best_len) begin
                    best_start <= run_start;
                    best_len   <= run_len;
                end
            end else begin
                cur_len <= '0;
            end
        end
    end

endmodule

// File: rtl/vref_sweep_ctrl.sv
// rtl/vref_sweep_ctrl.sv - MBTRAIN receiver Vref sweep sequencer with centre-of-run selection
module vref_sweep_ctrl
    import vref_cal_pkg::*;
#(
    parameter logic [VREF_W-1:0] VREF_MIN      = 4'd0,
    parameter logic [VREF_W-1:0] VREF_MAX      = 4'd15,
    parameter logic [VREF_W-1:0] VREF_DEFAULT  = 4'd8,
    parameter int                SETTLE_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic [LANES-1:0]  i_lane_mask,
    input  logic [LANES-1:0]  i_rx_lanes_result,
    input  logic              i_test_ack,
    output logic              o_pt_en,
    output logic [VREF_W-1:0] o_reciever_ref_voltage,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_fail,
    output logic [LEN_W-1:0]  o_best_len
);

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

    vref_state_t       state_q, state_d;
    logic [VREF_W-1:0] code_q, code_d;
    logic [VREF_W-1:0] vref_q, vref_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [LANES-1:0]  mask_q, mask_d;
    logic              pass_q, pass_d;
    logic              fail_q, fail_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              en_q;
    logic              trk_clear;
    logic              trk_update;
    logic [VREF_W-1:0] best_start;
    logic [LEN_W-1:0]  best_len;

    vref_run_tracker u_tracker (
        .clk        (clk),
        .rst        (rst),
        .clear      (trk_clear),
        .update     (trk_update),
        .pass       (pass_q),
        .code       (code_q),
        .best_start (best_start),
        .best_len   (best_len)
    );

    // State and datapath registers; en_q gives the rising-edge detect on i_en
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            code_q  <= '0;
            vref_q  <= VREF_DEFAULT;
            cnt_q   <= '0;
            mask_q  <= '0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            len_q   <= '0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            vref_q  <= vref_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            len_q   <= len_d;
            en_q    <= i_en;
        end
    end

    // Next-state and datapath updates; abort overrides everything, including a same-cycle ack
    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        vref_d     = vref_q;
        cnt_d      = cnt_q;
        mask_d     = mask_q;
        pass_d     = pass_q;
        fail_d     = fail_q;
        len_d      = len_q;
        trk_clear  = 1'b0;
        trk_update = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_en && !en_q) begin
                    mask_d    = i_lane_mask;
                    code_d    = VREF_MIN;
                    vref_d    = VREF_MIN;
                    cnt_d     = SETTLE_LOAD;
                    fail_d    = 1'b0;
                    len_d     = '0;
                    trk_clear = 1'b1;
                    state_d   = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = S_TEST;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_TEST: begin
                if (i_test_ack) begin
                    pass_d  = &(i_rx_lanes_result | ~mask_q);
                    state_d = S_EVAL;
                end
            end
            S_EVAL: begin
                trk_update = 1'b1;
                if (code_q == VREF_MAX) begin
                    state_d = S_FINAL;
                end else begin
                    code_d  = code_q + VREF_W'(1);
                    vref_d  = code_q + VREF_W'(1);
                    cnt_d   = SETTLE_LOAD;
                    state_d = S_SETTLE;
                end
            end
            S_FINAL: begin
                if (best_len == '0) begin
                    vref_d = VREF_DEFAULT;
                    fail_d = 1'b1;
                end else begin
                    vref_d = best_start + VREF_W'((best_len - LEN_W'(1)) >> 1);
                end
                len_d   = best_len;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (!i_en) begin
                    fail_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (!i_en && (state_q inside {S_SETTLE, S_TEST, S_EVAL, S_FINAL})) begin
            state_d    = S_IDLE;
            vref_d     = VREF_DEFAULT;
            fail_d     = 1'b0;
            trk_update = 1'b0;
        end
    end

    // Outputs decoded from the registered state so they change only on clock edges
    always_comb begin
        o_pt_en                = (state_q == S_TEST);
        o_busy                 = (state_q inside {S_SETTLE, S_TEST, S_EVAL, S_FINAL});
        o_done                 = (state_q == S_DONE);
        o_fail                 = fail_q;
        o_best_len             = len_q;
        o_reciever_ref_voltage = vref_q;
    end

endmodule

// File: tb/tb_vref_sweep_ctrl.sv
// tb/tb_vref_sweep_ctrl.sv - directed table-driven bench for vref_sweep_ctrl
module tb_vref_sweep_ctrl;

    logic        clk;
    logic        rst;
    logic        i_en;
    logic [15:0] i_lane_mask;
    logic [15:0] i_rx_lanes_result;
    logic        i_test_ack;
    logic        o_pt_en;
    logic [3:0]  o_reciever_ref_voltage;
    logic        o_busy;
    logic        o_done;
    logic        o_fail;
    logic [4:0]  o_best_len;

    int n_checks = 0;
    int n_errors = 0;

    vref_sweep_ctrl dut (
        .clk                    (clk),
        .rst                    (rst),
        .i_en                   (i_en),
        .i_lane_mask            (i_lane_mask),
        .i_rx_lanes_result      (i_rx_lanes_result),
        .i_test_ack             (i_test_ack),
        .o_pt_en                (o_pt_en),
        .o_reciever_ref_voltage (o_reciever_ref_voltage),
        .o_busy                 (o_busy),
        .o_done                 (o_done),
        .o_fail                 (o_fail),
        .o_best_len             (o_best_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] mask;
        logic [15:0] code_pass;
        logic [15:0] res_pass;
        logic [15:0] res_fail;
        int          ack_delay;
        bit          spur;
        logic [3:0]  exp_vref;
        logic [4:0]  exp_len;
        logic        exp_fail;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic wait_pt(input logic [3:0] code, input bit spur);
        int gap;
        bit seen;
        gap  = 0;
        seen = 1'b0;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            i_test_ack = 1'b0;
            if (o_pt_en) begin
                seen = 1'b1;
                break;
            end
            if (o_reciever_ref_voltage == code) gap++;
            if (spur && gap == 3) begin
                i_test_ack        = 1'b1;
                i_rx_lanes_result = 16'h0000;
            end
        end
        check($sformatf("pt_en_seen_c%0d", code), 32'(seen), 32'd1);
        check($sformatf("settle_gap_c%0d", code), 32'(gap), 32'd8);
        check($sformatf("vref_at_test_c%0d", code), 32'(o_reciever_ref_voltage), 32'(code));
    endtask

    task automatic finish_test(input logic [15:0] res, input int delay);
        for (int d = 0; d < delay; d++) begin
            @(negedge clk);
            check("pt_en_held", 32'(o_pt_en), 32'd1);
        end
        i_test_ack        = 1'b1;
        i_rx_lanes_result = res;
        @(negedge clk);
        i_test_ack = 1'b0;
        check("pt_en_drop", 32'(o_pt_en), 32'd0);
    endtask

    task automatic run_vec(input int k);
        vec_t v;
        bit   got_done;
        v = vecs[k];
        @(negedge clk);
        i_en        = 1'b0;
        i_lane_mask = v.mask;
        @(negedge clk);
        i_en = 1'b1;
        for (int c = 0; c < 16; c++) begin
            wait_pt(4'(c), v.spur);
            finish_test(v.code_pass[c] ? v.res_pass : v.res_fail, v.ack_delay);
        end
        got_done = 1'b0;
        for (int t = 0; t < 6; t++) begin
            if (o_done) begin
                got_done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check($sformatf("v%0d_done", k), 32'(got_done), 32'd1);
        check($sformatf("v%0d_vref", k), 32'(o_reciever_ref_voltage), 32'(v.exp_vref));
        check($sformatf("v%0d_best_len", k), 32'(o_best_len), 32'(v.exp_len));
        check($sformatf("v%0d_fail", k), 32'(o_fail), 32'(v.exp_fail));
        check($sformatf("v%0d_busy_done", k), 32'(o_busy), 32'd0);
        i_en = 1'b0;
        @(negedge clk);
        check($sformatf("v%0d_done_clr", k), 32'(o_done), 32'd0);
        check($sformatf("v%0d_fail_clr", k), 32'(o_fail), 32'd0);
        check($sformatf("v%0d_vref_hold", k), 32'(o_reciever_ref_voltage), 32'(v.exp_vref));
    endtask

    initial begin
        vecs[0] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 0,  1'b0, 4'd7,  5'd16, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h33F8, 16'hFFFF, 16'h0000, 0,  1'b0, 4'd6,  5'd7,  1'b0};
        vecs[2] = '{16'hFFFF, 16'h1C1C, 16'hFFFF, 16'h0000, 20, 1'b1, 4'd3,  5'd3,  1'b0};
        vecs[3] = '{16'hFFDF, 16'h0000, 16'hFFDF, 16'hFFDF, 0,  1'b0, 4'd7,  5'd16, 1'b0};
        vecs[4] = '{16'hFFFF, 16'h0000, 16'hFFDF, 16'hFFDF, 0,  1'b0, 4'd8,  5'd0,  1'b1};
        vecs[5] = '{16'hFFFF, 16'h8000, 16'hFFFF, 16'h0000, 0,  1'b0, 4'd15, 5'd1,  1'b0};
        vecs[6] = '{16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 0,  1'b1, 4'd0,  5'd1,  1'b0};
        vecs[7] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 0,  1'b0, 4'd7,  5'd16, 1'b0};
        vecs[8] = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'h7FFF, 0,  1'b0, 4'd8,  5'd0,  1'b1};

        rst               = 1'b1;
        i_en              = 1'b0;
        i_lane_mask       = 16'h0000;
        i_rx_lanes_result = 16'h0000;
        i_test_ack        = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_vref", 32'(o_reciever_ref_voltage), 32'd8);
        check("rst_pt_en", 32'(o_pt_en), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_fail", 32'(o_fail), 32'd0);
        check("rst_best_len", 32'(o_best_len), 32'd0);
        rst = 1'b0;

        for (int k = 0; k < 9; k++) run_vec(k);

        // Abort in TEST at code 5 together with an ack
        @(negedge clk);
        i_lane_mask = 16'hFFFF;
        @(negedge clk);
        i_en = 1'b1;
        for (int c = 0; c < 5; c++) begin
            wait_pt(4'(c), 1'b0);
            finish_test(16'hFFFF, 0);
        end
        wait_pt(4'd5, 1'b0);
        i_en              = 1'b0;
        i_test_ack        = 1'b1;
        i_rx_lanes_result = 16'hFFFF;
        @(negedge clk);
        i_test_ack = 1'b0;
        check("abort_pt_en", 32'(o_pt_en), 32'd0);
        check("abort_busy", 32'(o_busy), 32'd0);
        check("abort_vref", 32'(o_reciever_ref_voltage), 32'd8);
        check("abort_done", 32'(o_done), 32'd0);
        repeat (3) @(negedge clk);
        check("abort_done_later", 32'(o_done), 32'd0);
        check("abort_vref_later", 32'(o_reciever_ref_voltage), 32'd8);

        run_vec(0);

        // Asynchronous reset in the middle of SETTLE
        @(negedge clk);
        i_en = 1'b1;
        repeat (3) @(negedge clk);
        check("pre_rst_busy", 32'(o_busy), 32'd1);
        check("pre_rst_vref", 32'(o_reciever_ref_voltage), 32'd0);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("async_rst_vref", 32'(o_reciever_ref_voltage), 32'd8);
        check("async_rst_busy", 32'(o_busy), 32'd0);
        check("async_rst_pt_en", 32'(o_pt_en), 32'd0);
        i_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("post_rst_busy", 32'(o_busy), 32'd0);
        check("post_rst_done", 32'(o_done), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
